mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4:1 bit mux among 4 requesters.
//  Grants one requester at a time, drives the mux select and returns the
//  registered mux output with a valid flag. The grant is held until the owner
//  drops its request or the HOLD_MAX tenure expires.
//  Sits directly in front of the 4:1 mux datapath and owns its select lines.
// PARAMETERS
//  HOLD_MAX  4  max consecutive grant cycles per tenure (legal range 1..255)
//  CNT_W     8  tenure counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  req       in   4  request per requester; level, held high while access is wanted
//  in        in   4  mux data inputs, bit i belongs to requester i
//  gnt       out  4  one-hot grant, registered; 0 = idle
//  sel       out  2  mux select, registered; equals the index of the set gnt bit
//  busy      out  1  1 while in GRANT state (equals |gnt)
//  out       out  1  registered mux output in[sel]; 0 when not valid
//  out_vld   out  1  out is valid; lags gnt by exactly 1 cycle
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - gnt=0, sel=2'b00, busy=0, out=0, out_vld=0.
//   - state=IDLE, cnt=0, ptr=0 (requester 0 has highest priority).
//  Arbitration function:
//   - pick(ptr,r) = first i in cyclic order ptr, ptr+1, ..., ptr+3 (mod 4) with r[i]=1.
//  IDLE:
//   - If req!=0 at edge: gnt<=onehot(pick(ptr,req)), sel<=index, cnt<=1, state<=GRANT.
//   - Grant latency is 1 cycle after req is sampled.
//   - If req==0: stay in IDLE, gnt=0, sel holds its last value.
//  GRANT (owner o = sel):
//   - Keep grant when req[o]=1 and cnt<HOLD_MAX: gnt/sel unchanged, cnt<=cnt+1.
//   - Release when req[o]=0 or cnt==HOLD_MAX: ptr<=o+1 mod 4; then evaluate pick(o+1,req).
//       r = req with owner bit kept if still high; the owner is lowest priority.
//       If r!=0: grant the winner next cycle, cnt<=1. Handover has no idle gap.
//       If r==0: gnt<=0, state<=IDLE.
//   - A lone requester holding req is re-granted back-to-back.
//       gnt stays constant; cnt restarts at 1 every HOLD_MAX cycles.
//  Datapath:
//   - out_vld<=busy.
//   - out<=busy ? in[sel] : 0.
//   - Both are registered, so out reflects in one cycle after the grant edge.
//  Invariants:
//   - gnt is always 0 or one-hot.
//   - gnt bit i is set only if req[i] was 1 at the granting edge.
//   - sel==index(gnt) whenever busy=1.
//   - cnt never exceeds HOLD_MAX.
//  Simultaneous events:
//   - Owner drop and tenure expiry in the same cycle are treated as one release.
//   - New requests arriving during a tenure do not preempt it.
//  Reset mid-grant:
//   - All outputs clear immediately (asynchronously).
//   - First grant after rst_n rises uses ptr=0.
// TESTING
//  1. rst_n=0 with req=4'hF, in=4'hF -> gnt=0, sel=0, busy=0, out=0, out_vld=0
//     throughout; asserted asynchronously mid-cycle.
//  2. HOLD_MAX=4, req=4'hF held 20 cycles -> gnt cycles 0001,0010,0100,1000,0001.
//     Each grant lasts 4 cycles; no idle cycle between grants.
//  3. req=4'b0100 held 10 cycles -> gnt=4'b0100 from cycle 1 and stays constant;
//     busy=1 throughout; cnt wraps 4->1.
//  4. req=4'b0010 for 2 cycles then 0 -> gnt=0 one cycle after the drop, ptr=2.
//     Then req=4'b0011 -> gnt=4'b0001 (search order 2,3,0).
//  5. Grant to requester 3 with in=4'b1000 -> out=1, out_vld=1 one cycle after gnt.
//     in=4'b0111 -> out=0. After release, out_vld=0 and out=0.
//  6. rst_n pulsed low mid-tenure of requester 2 -> all outputs 0 immediately.
//     With req=4'hF after release -> first gnt=4'b0001.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Request/data/grant bundle between four requesters and the
//               round-robin arbiter that owns the shared 4:1 bit mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_arbiter_if;
    logic [3:0] req;      // level request per requester
    logic [3:0] in;       // mux data inputs, bit i belongs to requester i
    logic [3:0] gnt;      // one-hot grant, 0 = idle
    logic [1:0] sel;      // mux select, index of the set gnt bit
    logic       busy;     // arbiter holds a grant
    logic       out;      // registered mux output
    logic       out_vld;  // out is valid

    // Requester side: drives requests and data, observes grant and result
    modport master (
        output req,
        output in,
        input  gnt,
        input  sel,
        input  busy,
        input  out,
        input  out_vld
    );

    // Arbiter side
    modport slave (
        input  req,
        input  in,
        output gnt,
        output sel,
        output busy,
        output out,
        output out_vld
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 bit mux among four
//               requesters. A grant is held while the owner keeps requesting,
//               up to HOLD_MAX cycles per tenure, then passed on without an
//               idle gap. The selected mux bit is returned registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4,   // max consecutive grant cycles (1..255)
    parameter int CNT_W    = 8    // tenure counter width, 2**CNT_W > HOLD_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr;
    logic             r_out;
    logic             r_out_vld;
    logic [2:0]       w_pick;   // {found, index}
    logic             w_busy;

    // First requester at or after 'start' in cyclic order; MSB flags a hit.
    // Scanning from the far end lets the nearest hit overwrite the others.
    function automatic logic [2:0] pick(input logic [1:0] start,
                                        input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_busy = (r_state == ST_GRANT);

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_cnt   <= '0;
            r_ptr   <= 2'b00;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
        end
    end

    // Next grant: keep the owner within its tenure, otherwise search onward
    // from the slot after the owner so the owner itself ranks last.
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_sel   = r_sel;
        w_cnt   = r_cnt;
        w_ptr   = r_ptr;
        w_pick  = 3'b000;
        case (r_state)
            ST_IDLE: begin
                w_pick = pick(r_ptr, bus.req);
                if (w_pick[2]) begin
                    w_state = ST_GRANT;
                    w_gnt   = 4'b0001 << w_pick[1:0];
                    w_sel   = w_pick[1:0];
                    w_cnt   = c_cnt_one;
                end else begin
                    w_gnt   = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (bus.req[r_sel] && (r_cnt < c_hold_max)) begin
                    w_cnt = r_cnt + c_cnt_one;
                end else begin
                    w_ptr  = r_sel + 2'd1;
                    w_pick = pick(r_sel + 2'd1, bus.req);
                    if (w_pick[2]) begin
                        w_gnt = 4'b0001 << w_pick[1:0];
                        w_sel = w_pick[1:0];
                        w_cnt = c_cnt_one;
                    end else begin
                        w_state = ST_IDLE;
                        w_gnt   = 4'b0000;
                        w_cnt   = '0;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 4'b0000;
                w_cnt   = '0;
            end
        endcase
    end

    // Registered mux output, one cycle behind the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_busy;
            r_out     <= w_busy ? bus.in[r_sel] : 1'b0;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.sel     = r_sel;
    assign bus.busy    = w_busy;
    assign bus.out     = r_out;
    assign bus.out_vld = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter: directed vector
//               table, hand sequences for tenure/reset corners, and random
//               traffic against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       out;
        logic       vld;
    } vec_t;

    vec_t tbl [12];

    // Reference model state: owner index (-1 = idle), tenure length, pointer
    int         m_owner;
    int         m_ten;
    int         m_ptr;
    int         m_sel;
    logic       m_out;
    logic       m_vld;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] gnt,
                           input logic [1:0] sel, input logic busy,
                           input logic out, input logic vld);
        chk({tag, ".gnt"},     32'(bus.gnt),     32'(gnt));
        chk({tag, ".sel"},     32'(bus.sel),     32'(sel));
        chk({tag, ".busy"},    32'(bus.busy),    32'(busy));
        chk({tag, ".out"},     32'(bus.out),     32'(out));
        chk({tag, ".out_vld"}, 32'(bus.out_vld), 32'(vld));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before any edge
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(tag, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all({tag, "_hold"}, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ten   = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_out   = 1'b0;
        m_vld   = 1'b0;
    endtask

    // One clock edge of the arbiter as described by its rules
    task automatic model_step(input logic [3:0] req, input logic [3:0] din);
        int start;
        int winner;
        m_vld = (m_owner >= 0);
        m_out = (m_owner >= 0) ? din[m_owner] : 1'b0;
        if (m_owner >= 0 && req[m_owner] && m_ten < HOLD) begin
            m_ten = m_ten + 1;
        end else begin
            if (m_owner >= 0) begin
                start = (m_owner + 1) % 4;
                m_ptr = start;
            end else begin
                start = m_ptr;
            end
            winner = -1;
            for (int k = 0; k < 4; k++) begin
                if (winner < 0 && req[(start + k) % 4]) winner = (start + k) % 4;
            end
            m_owner = winner;
            if (winner >= 0) begin
                m_ten = 1;
                m_sel = winner;
            end else begin
                m_ten = 0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Directed vectors from a clean reset: {req, in} -> outputs after edge
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};

        // Reset held with all requests and data high
        rst_n   = 1'b0;
        bus.req = 4'hF;
        bus.in  = 4'hF;
        #1;
        chk_all("rst_init", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_all("rst_held", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        bus.req = 4'h0;
        bus.in  = 4'h0;
        rst_n   = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.req = tbl[i].req;
            bus.in  = tbl[i].din;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel,
                    tbl[i].busy, tbl[i].out, tbl[i].vld);
        end

        // Reset in the middle of requester 0's tenure
        do_reset("rst_mid0");

        // All four requesting: rotation with HOLD cycles each, no gaps
        bus.req = 4'hF;
        bus.in  = 4'h0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("rot_gnt_c%0d", c), 32'(bus.gnt),
                32'(4'b0001 << (((c - 1) / HOLD) % 4)));
            chk($sformatf("rot_busy_c%0d", c), 32'(bus.busy), 32'd1);
        end
        do_reset("rst_rot");

        // Lone requester 2: re-granted back-to-back, grant never drops
        bus.req = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("lone_gnt_c%0d", c), 32'(bus.gnt), 32'(4'b0100));
            chk($sformatf("lone_sel_c%0d", c), 32'(bus.sel), 32'd2);
            chk($sformatf("lone_busy_c%0d", c), 32'(bus.busy), 32'd1);
        end

        // Reset mid-tenure of requester 2; first grant afterwards uses ptr=0
        do_reset("rst_mid2");
        bus.req = 4'hF;
        tick();
        chk("post_rst_gnt", 32'(bus.gnt), 32'(4'b0001));

        // Random traffic against the model, with occasional async resets
        do_reset("rst_rand");
        model_reset();
        bus.req = 4'h0;
        bus.in  = 4'h0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r;
            logic [3:0] exp_gnt;
            r = bus.req;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            bus.req = r;
            bus.in  = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rst_rand_mid");
                model_reset();
            end else begin
                model_step(bus.req, bus.in);
                tick();
                exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
                chk_all($sformatf("rand%0d", c), exp_gnt, 2'(m_sel),
                        (m_owner >= 0), m_out, m_vld);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
